uart_tx_fsm: RTL
================

# uart_tx_fsm

Standalone UART transmitter: accepts one byte per valid/ready handshake and serialises it onto `tdo` as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits. Frame format parameters match `uart_receiver` (`P`, `s`, `TIMER`), so `tdo` connects directly to the receiver's serial input. It is the handshake-driven transmit engine for peripherals that need no FIFO, such as a bus-mapped UART data register or a debug console.

## Interface
- `P`, default 0: parity mode. 0 = none, 1 = odd, 2 = even. 3 is illegal.
- `s`, default 1: number of stop bits, 1 or 2.
- `TIMER`, default 5: clock cycles per bit, ≥ 2. The bit counter width is `$clog2(TIMER)`.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  synchronous, active-low reset (low = reset).
- `tx_valid`  input  1  byte offered on `tx_data`.
- `tx_data`  input  8  byte to send, sampled only on the accept edge.
- `tx_ready`  output  1  transmitter idle and able to accept a byte.
- `tdo`  output  1  serial line; idle level is high.
- `busy`  output  1  frame in progress.
- `tx_done`  output  1  one-cycle pulse at frame end.
- `brk`  input  1  line break request. Present only with `UART_TX_BREAK_EN`.

## Operation
- All outputs are registered.
- Values while `reset` is low: `tdo`=1, `tx_ready`=0, `busy`=0, `tx_done`=0, state IDLE.
- `tx_ready` rises on the first edge after `reset` goes high.
- States are IDLE → START → DATA → PARITY (only if P≠0) → STOP → IDLE.
- Accept condition: `tx_valid && tx_ready` at a rising edge. On that edge:
  - `tx_data` is latched into the shift register.
  - State becomes START, `tdo`←0, `tx_ready`←0, `busy`←1.
- `tx_data` changes after the accept edge have no effect on the frame.
- The baud counter counts 0..TIMER-1 within each bit. The state or bit advances when the count reaches TIMER-1.
- DATA sends bit 0 first. A 3-bit index moves from 0 to 7, then the FSM exits.
- Parity bit value:
  - Odd (P=1): `~^data`, so the total number of ones in data plus parity is odd.
  - Even (P=2): `^data`.
- STOP holds `tdo`=1 for `s`×TIMER cycles.
- At the end of the last stop bit, on one edge:
  - State becomes IDLE.
  - `tx_done`←1 for one cycle.
  - `busy`←0, `tx_ready`←1.
- With `tx_valid` held high, the next byte is accepted on the following edge. Frames are therefore separated by exactly one extra idle-high clock.
- Reset mid-frame:
  - The frame is aborted on the edge that samples `reset` low, and `tdo`=1 from then on.
  - No `tx_done` is issued.
  - The latched byte is discarded.
- `tx_valid` while `tx_ready`=0 is ignored. No byte is queued.

## Timing
- Frame length is N = 1 + 8 + (P≠0) + `s` bits.
- With the accept edge at cycle k:
  - `tdo` is low during cycles k+1..k+TIMER.
  - Data bit i occupies cycles k+1+(1+i)·TIMER .. k+(2+i)·TIMER.
  - `tx_done` is high during cycle k+N·TIMER+1.
- Earliest next accept edge: k+N·TIMER+1.
- Latency from accept edge to the start bit on `tdo`: 1 cycle.

## Configuration
- `UART_TX_BREAK_EN` defined:
  - Adds the `brk` input.
  - In IDLE with `brk`=1: `tdo`←0 and `tx_ready`←0.
  - On the edge after `brk` falls: `tdo`←1 and `tx_ready`←1.
  - `brk` during a frame is ignored until the frame completes. It is then honoured on the edge that would otherwise re-assert `tx_ready`.
  - In IDLE, `brk` has priority over `tx_valid`.
- `UART_TX_BREAK_EN` undefined: the `brk` port does not exist and `tdo` is low only during start, data and parity bits.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release.
  - During reset: `tdo`=1, `tx_ready`=0, `busy`=0.
  - `tx_ready`=1 exactly one edge after release.
- Basic frame (P=0, s=1, TIMER=5): send 0x05.
  - `tdo` sequence 0,1,0,1,0,0,0,0,0,1, each bit 5 cycles.
  - `tx_done` pulses 51 cycles after the accept edge.
- Parity (TIMER=5, s=2): send 0xAA (four ones).
  - P=1 gives parity bit 1. P=2 gives parity bit 0.
  - Frame is 60 cycles with two stop bits.
  - A `uart_receiver` with matching parameters recovers 0xAA.
- Back-to-back: hold `tx_valid`=1 with 0x06, change `tx_data` to 0x07 during frame 1.
  - Frame 1 carries 0x06 unaltered.
  - Frame 2 carries 0x07.
  - Exactly one extra idle-high cycle between the frames.
- Reset mid-frame: drive `reset`=0 during data bit 3 of 0x0F.
  - `tdo`=1 from the next edge, no `tx_done`.
  - After release, a 0xAB frame is correct.
- Break (`UART_TX_BREAK_EN`): assert `brk` for 20 cycles in IDLE, then for 10 cycles during a frame.
  - In IDLE: `tdo`=0 and `tx_ready`=0 for the 20 cycles.
  - During the frame: the frame completes intact, then `tdo` is held low until `brk` falls.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// Handshake-driven UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Optional UART_TX_BREAK_EN adds a brk input that holds the line low while idle.
module uart_tx_fsm #(
    parameter int unsigned P     = 0,
    parameter int unsigned s     = 1,
    parameter int unsigned TIMER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic       brk,
`endif
    output logic       tx_ready,
    output logic       tdo,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CW       = $clog2(TIMER);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMER - 1);
    localparam logic [2:0] STOP_LAST = 3'(s - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    idx_q, idx_n;
    logic [7:0]    shift_q, shift_n;
    logic          tdo_n, ready_n, busy_n, done_n;
    logic          brk_req;
    logic          bit_end;
    logic          par_bit;

`ifdef UART_TX_BREAK_EN
    assign brk_req = brk;
`else
    assign brk_req = 1'b0;
`endif

    assign bit_end = (cnt_q == CNT_LAST);
    assign par_bit = (P == 1) ? ~(^shift_q) : (^shift_q);

    // State and output registers; reset aborts any frame and discards the byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tdo      <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            idx_q    <= idx_n;
            shift_q  <= shift_n;
            tdo      <= tdo_n;
            tx_ready <= ready_n;
            busy     <= busy_n;
            tx_done  <= done_n;
        end
    end

    // Next-state and next-output logic; idx doubles as stop-bit counter in STOP
    always_comb begin
        state_n = state_q;
        cnt_n   = bit_end ? '0 : cnt_q + CW'(1);
        idx_n   = idx_q;
        shift_n = shift_q;
        tdo_n   = tdo;
        ready_n = tx_ready;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (brk_req) begin
                    tdo_n   = 1'b0;
                    ready_n = 1'b0;
                end else if (tx_valid && tx_ready) begin
                    shift_n = tx_data;
                    state_n = START;
                    tdo_n   = 1'b0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                end else begin
                    tdo_n   = 1'b1;
                    ready_n = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tdo_n   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_n = '0;
                        if (P != 0) begin
                            state_n = PARITY;
                            tdo_n   = par_bit;
                        end else begin
                            state_n = STOP;
                            tdo_n   = 1'b1;
                        end
                    end else begin
                        idx_n = idx_q + 3'd1;
                        tdo_n = shift_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    idx_n   = '0;
                    tdo_n   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        ready_n = ~brk_req;
                        tdo_n   = ~brk_req;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tdo_n   = 1'b1;
                ready_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
